// File: rtl/prog_seq_detector.sv
// -----------------------------------------------------------------------------
// prog_seq_detector
//
// Serial bit-pattern detector with a run-time programmable pattern, length and
// overlap mode. Incoming bits are shifted into a short history register; the
// match decision compares the history plus the bit currently on the input
// against the programmed pattern. Because the current bit takes part in the
// compare, dec is a combinational (Mealy) flag. All stored state is registered.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in           serial data bit
//   in_valid     qualifies in; the bit is consumed on the rising edge
//   cfg_we       configuration write strobe (takes priority over in_valid)
//   cfg_pattern  new pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      new pattern length, accepted range 2..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      synchronous clear of match_cnt
//   dec          match flag for the bit currently presented
//   match_cnt    saturating match counter
//   cfg_err      one-cycle pulse after a rejected configuration write
// -----------------------------------------------------------------------------
module prog_seq_detector #(
   parameter int          MAX_LEN     = 8,
   parameter int          CNT_W       = 8,
   parameter logic [15:0] RST_PATTERN = 16'b0000_0000_0000_1011,
   parameter int          RST_LEN     = 4,
   parameter bit          RST_OVERLAP = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in,
   input  logic               in_valid,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [4:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               dec,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   // fill only needs to count up to MAX_LEN-1
   localparam int                FILL_W   = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);
   localparam logic [4:0]        LEN_MAX  = 5'(MAX_LEN);
   localparam logic [4:0]        LEN_MIN  = 5'd2;

   localparam logic [MAX_LEN-1:0] PAT_RST  = RST_PATTERN[MAX_LEN-1:0];
   localparam logic [4:0]         LEN_RST  = 5'(RST_LEN);

   // active configuration
   logic [MAX_LEN-1:0] pattern_q;
   logic [4:0]         len_q;
   logic               overlap_q;

   // history: newest bit at [0]
   logic [MAX_LEN-2:0] hist_q;
   logic [FILL_W-1:0]  fill_q;

   logic               cfg_ok;
   logic               consumed;
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] len_mask;
   logic               hit;
   logic               fill_ok;
   logic               cnt_sat;

   // ------------------------------------------------------------------------
   // Match decision
   // ------------------------------------------------------------------------
   assign cfg_ok   = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
   assign consumed = in_valid && !cfg_we;

   // window[len-1:0] is {hist[len-2:0], in}; bits above len-1 are masked off
   assign window = {hist_q, in};

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   assign hit     = (((window ^ pattern_q) & len_mask) == '0);
   assign fill_ok = (5'(fill_q) >= (len_q - 5'd1));

   // rst_n gates dec so the flag is low throughout reset, not just after the
   // state has settled
   assign dec = rst_n && consumed && fill_ok && hit;

   // ------------------------------------------------------------------------
   // Configuration registers and error pulse
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q <= PAT_RST;
         len_q     <= LEN_RST;
         overlap_q <= RST_OVERLAP;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_we && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
         end
      end
   end

   // ------------------------------------------------------------------------
   // History and fill count
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (cfg_we) begin
         // any write, accepted or rejected, restarts pattern collection
         fill_q <= '0;
      end else if (in_valid) begin
         hist_q <= window[MAX_LEN-2:0];
         if (dec && !overlap_q) begin
            // non-overlapping: none of the matched bits may be reused
            fill_q <= '0;
         end else if (!dec && (fill_q != FILL_MAX)) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Match counter
   // ------------------------------------------------------------------------
   assign cnt_sat = &match_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         // a match on the clearing edge is counted rather than lost
         match_cnt <= dec ? CNT_W'(1) : '0;
      end else if (dec && !cnt_sat) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_seq_detector.sv
module tb_prog_seq_detector;

   logic       clk;
   logic       rst_n;

   // default instance (MAX_LEN=8, CNT_W=8)
   logic       in_a, valid_a, we_a, ovl_a, clr_a;
   logic [7:0] pat_a;
   logic [4:0] len_a;
   logic       dec_a, err_a;
   logic [7:0] cnt_a;

   // narrow-counter instance (CNT_W=2)
   logic       in_b, valid_b, we_b, ovl_b, clr_b;
   logic [7:0] pat_b;
   logic [4:0] len_b;
   logic       dec_b, err_b;
   logic [1:0] cnt_b;

   int n_cmp  = 0;
   int n_fail = 0;

   prog_seq_detector u_dut (
      .clk(clk), .rst_n(rst_n), .in(in_a), .in_valid(valid_a), .cfg_we(we_a),
      .cfg_pattern(pat_a), .cfg_len(len_a), .cfg_overlap(ovl_a), .cnt_clr(clr_a),
      .dec(dec_a), .match_cnt(cnt_a), .cfg_err(err_a)
   );

   prog_seq_detector #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in(in_b), .in_valid(valid_b), .cfg_we(we_b),
      .cfg_pattern(pat_b), .cfg_len(len_b), .cfg_overlap(ovl_b), .cnt_clr(clr_b),
      .dec(dec_b), .match_cnt(cnt_b), .cfg_err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // present one valid bit to the default instance and check dec before the edge
   task automatic send_a(input logic b, input logic exp_dec, input string tag);
      @(negedge clk);
      in_a = b; valid_a = 1'b1; we_a = 1'b0; clr_a = 1'b0;
      #1 check(tag, 32'(dec_a), 32'(exp_dec));
      @(posedge clk);
   endtask

   task automatic send_b(input logic b, input logic exp_dec, input string tag);
      @(negedge clk);
      in_b = b; valid_b = 1'b1; we_b = 1'b0; clr_b = 1'b0;
      #1 check(tag, 32'(dec_b), 32'(exp_dec));
      @(posedge clk);
   endtask

   task automatic idle_a();
      @(negedge clk);
      valid_a = 1'b0; we_a = 1'b0; clr_a = 1'b0; in_a = 1'b1;
      #1;
   endtask

   task automatic cfg_a(input logic [7:0] p, input logic [4:0] l, input logic o);
      @(negedge clk);
      we_a = 1'b1; pat_a = p; len_a = l; ovl_a = o;
      valid_a = 1'b1; in_a = 1'b1;
      #1 check("cfg_we_blocks_dec", 32'(dec_a), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      in_a = 1'b1; valid_a = 1'b1; we_a = 1'b0; ovl_a = 1'b0; clr_a = 1'b0;
      pat_a = '0; len_a = '0;
      in_b = 1'b0; valid_b = 1'b0; we_b = 1'b0; ovl_b = 1'b0; clr_b = 1'b0;
      pat_b = '0; len_b = '0;

      // reset state (in_valid held high: dec must still be 0)
      repeat (2) @(posedge clk);
      #1;
      check("rst_dec", 32'(dec_a), 32'd0);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      @(negedge clk);
      valid_a = 1'b0;
      rst_n = 1'b1;

      // defaults 1011 overlapping: 1,0,1,1,0,1,1
      send_a(1, 0, "ov_b1"); send_a(0, 0, "ov_b2"); send_a(1, 0, "ov_b3");
      send_a(1, 1, "ov_b4"); send_a(0, 0, "ov_b5"); send_a(1, 0, "ov_b6");
      send_a(1, 1, "ov_b7");
      idle_a();
      check("ov_cnt", 32'(cnt_a), 32'd2);

      // clear counter
      @(negedge clk); clr_a = 1'b1; @(posedge clk);
      idle_a();
      check("clr_cnt", 32'(cnt_a), 32'd0);

      // non-overlapping 1011
      cfg_a(8'b0000_1011, 5'd4, 1'b0);
      idle_a();
      check("nov_cfg_err", 32'(err_a), 32'd0);
      send_a(1, 0, "nov_b1"); send_a(0, 0, "nov_b2"); send_a(1, 0, "nov_b3");
      send_a(1, 1, "nov_b4"); send_a(0, 0, "nov_b5"); send_a(1, 0, "nov_b6");
      send_a(1, 0, "nov_b7");
      idle_a();
      check("nov_cnt1", 32'(cnt_a), 32'd1);
      send_a(1, 0, "nov_c1"); send_a(0, 0, "nov_c2"); send_a(1, 0, "nov_c3");
      send_a(1, 1, "nov_c4");
      idle_a();
      check("nov_cnt2", 32'(cnt_a), 32'd2);

      // back to defaults via reset; asynchronous effect checked mid-cycle
      @(negedge clk); #2 rst_n = 1'b0;
      #1 check("async_rst_cnt", 32'(cnt_a), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // gaps are transparent
      send_a(1, 0, "gap_b1"); idle_a(); check("gap_dec1", 32'(dec_a), 32'd0); @(posedge clk);
      send_a(0, 0, "gap_b2"); idle_a(); check("gap_dec2", 32'(dec_a), 32'd0); @(posedge clk);
      send_a(1, 0, "gap_b3"); idle_a(); check("gap_dec3", 32'(dec_a), 32'd0); @(posedge clk);
      send_a(1, 1, "gap_b4");
      idle_a();
      check("gap_cnt", 32'(cnt_a), 32'd1);

      // rejected writes: len 0 then len 9
      @(negedge clk); we_a = 1'b1; len_a = 5'd0; pat_a = 8'hFF; ovl_a = 1'b0;
      @(posedge clk);
      idle_a();
      check("err_len0_pulse", 32'(err_a), 32'd1);
      @(negedge clk); #1 check("err_len0_clear", 32'(err_a), 32'd0);
      @(negedge clk); we_a = 1'b1; len_a = 5'd9;
      @(posedge clk);
      idle_a();
      check("err_len9_pulse", 32'(err_a), 32'd1);
      @(negedge clk); #1 check("err_len9_clear", 32'(err_a), 32'd0);
      // defaults retained, including overlap
      send_a(1, 0, "keep_b1"); send_a(0, 0, "keep_b2"); send_a(1, 0, "keep_b3");
      send_a(1, 1, "keep_b4"); send_a(0, 0, "keep_b5"); send_a(1, 0, "keep_b6");
      send_a(1, 1, "keep_b7");
      idle_a();
      check("keep_cnt", 32'(cnt_a), 32'd3);

      // narrow counter: pattern 11 len 2 (upper pattern bits must be ignored)
      @(negedge clk); we_b = 1'b1; pat_b = 8'b1010_0111; len_b = 5'd2; ovl_b = 1'b1;
      @(posedge clk);
      @(negedge clk); we_b = 1'b0;
      send_b(1, 0, "sat_b1");
      for (int i = 2; i <= 8; i++) send_b(1, 1, "sat_bn");
      @(negedge clk); valid_b = 1'b0; #1;
      check("sat_cnt", 32'(cnt_b), 32'd3);
      @(negedge clk); in_b = 1'b1; valid_b = 1'b1; clr_b = 1'b1;
      #1 check("sat_clr_dec", 32'(dec_b), 32'd1);
      @(posedge clk);
      @(negedge clk); valid_b = 1'b0; clr_b = 1'b0; #1;
      check("sat_clr_cnt", 32'(cnt_b), 32'd1);

      // reset mid-sequence discards partial match
      send_a(1, 0, "mid_b1"); send_a(0, 0, "mid_b2"); send_a(1, 0, "mid_b3");
      @(negedge clk); valid_a = 1'b0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      send_a(1, 0, "mid_after");
      idle_a();
      check("mid_cnt", 32'(cnt_a), 32'd0);
      send_a(1, 0, "mid_c1"); send_a(0, 0, "mid_c2"); send_a(1, 0, "mid_c3");
      send_a(1, 1, "mid_c4");
      idle_a();
      check("mid_cnt2", 32'(cnt_a), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
